// File: rtl/controle_porta_elevador.sv
// Elevator car door controller: opens on arrival/request, holds open for a timed
// window, closes; obstruction reopens the door and repeated reopenings raise falha_porta.
module controle_porta_elevador #(
    parameter int T_ABRIR   = 4,
    parameter int T_ABERTA  = 16,
    parameter int T_FECHAR  = 4,
    parameter int MAX_REAB  = 3,
    parameter int LARG_CONT = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       chegou_andar,
    input  logic       botao_abrir,
    input  logic       botao_fechar,
    input  logic       sensor_obstrucao,
    input  logic       alerta,
    input  logic [1:0] quantidade_pessoas,
    output logic       porta_aberta,
    output logic       motor_abrir,
    output logic       motor_fechar,
    output logic       liberar_movimento,
    output logic       falha_porta,
    output logic [1:0] estado
);

    localparam logic [1:0] FECHADA  = 2'b00;
    localparam logic [1:0] ABRINDO  = 2'b01;
    localparam logic [1:0] ABERTA   = 2'b10;
    localparam logic [1:0] FECHANDO = 2'b11;

    localparam int RW = $clog2(MAX_REAB + 1);

    localparam logic [LARG_CONT-1:0] FIM_ABRIR  = LARG_CONT'(T_ABRIR - 1);
    localparam logic [LARG_CONT-1:0] FIM_ABERTA = LARG_CONT'(T_ABERTA - 1);
    localparam logic [LARG_CONT-1:0] FIM_FECHAR = LARG_CONT'(T_FECHAR - 1);
    localparam logic [RW-1:0]        REAB_MAX   = RW'(MAX_REAB);

    logic [1:0]           estado_nxt;
    logic [LARG_CONT-1:0] timer, timer_nxt;
    logic [RW-1:0]        n_reab, n_reab_nxt;
    logic                 reinicia;

    // A full car (alerta or three occupants) turns a close request into a restart.
    assign reinicia = botao_abrir | sensor_obstrucao | alerta |
                      (botao_fechar & (quantidade_pessoas == 2'd3));

    always_comb begin
        estado_nxt = estado;
        timer_nxt  = timer + LARG_CONT'(1);
        n_reab_nxt = n_reab;
        case (estado)
            FECHADA: begin
                timer_nxt = '0;
                if (chegou_andar | botao_abrir)
                    estado_nxt = ABRINDO;
            end
            ABRINDO: begin
                if (timer == FIM_ABRIR) begin
                    estado_nxt = ABERTA;
                    timer_nxt  = '0;
                end
            end
            ABERTA: begin
                if (reinicia) begin
                    timer_nxt = '0;
                end else if (botao_fechar || timer == FIM_ABERTA) begin
                    estado_nxt = FECHANDO;
                    timer_nxt  = '0;
                end
            end
            default: begin
                // Obstruction takes priority over expiry: reopen rather than close on it.
                if (sensor_obstrucao | botao_abrir) begin
                    estado_nxt = ABRINDO;
                    timer_nxt  = '0;
                    if (sensor_obstrucao && n_reab != REAB_MAX)
                        n_reab_nxt = n_reab + RW'(1);
                end else if (timer == FIM_FECHAR) begin
                    estado_nxt = FECHADA;
                    timer_nxt  = '0;
                    n_reab_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado            <= FECHADA;
            timer             <= '0;
            n_reab            <= '0;
            porta_aberta      <= 1'b0;
            motor_abrir       <= 1'b0;
            motor_fechar      <= 1'b0;
            liberar_movimento <= 1'b0;
            falha_porta       <= 1'b0;
        end else begin
            estado            <= estado_nxt;
            timer             <= timer_nxt;
            n_reab            <= n_reab_nxt;
            porta_aberta      <= (estado_nxt == ABERTA);
            motor_abrir       <= (estado_nxt == ABRINDO);
            motor_fechar      <= (estado_nxt == FECHANDO);
            liberar_movimento <= (estado_nxt == FECHADA);
            falha_porta       <= (n_reab_nxt == REAB_MAX);
        end
    end

endmodule

// File: tb/tb_controle_porta_elevador.sv
// Directed, table-driven bench for the elevator door controller; each record holds
// inputs for a run of cycles plus the expected state and fault flag after every edge.
module tb_controle_porta_elevador;

    logic       clock = 1'b0;
    logic       reset;
    logic       chegou_andar, botao_abrir, botao_fechar, sensor_obstrucao, alerta;
    logic [1:0] quantidade_pessoas;
    logic       porta_aberta, motor_abrir, motor_fechar, liberar_movimento, falha_porta;
    logic [1:0] estado;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    controle_porta_elevador dut (
        .clock              (clock),
        .reset              (reset),
        .chegou_andar       (chegou_andar),
        .botao_abrir        (botao_abrir),
        .botao_fechar       (botao_fechar),
        .sensor_obstrucao   (sensor_obstrucao),
        .alerta             (alerta),
        .quantidade_pessoas (quantidade_pessoas),
        .porta_aberta       (porta_aberta),
        .motor_abrir        (motor_abrir),
        .motor_fechar       (motor_fechar),
        .liberar_movimento  (liberar_movimento),
        .falha_porta        (falha_porta),
        .estado             (estado)
    );

    typedef struct {
        logic       ch, ab, fe, ob, al;
        logic [1:0] qt;
        int         rep;
        logic [1:0] st;
        logic       fa;
    } vec_t;

    vec_t vecs[$];

    localparam logic [1:0] FD = 2'b00, AB = 2'b01, AT = 2'b10, FC = 2'b11;

    function automatic void v(input logic ch, ab, fe, ob, al, input logic [1:0] qt,
                              input int rep, input logic [1:0] st, input logic fa);
        vec_t r;
        r.ch = ch; r.ab = ab; r.fe = fe; r.ob = ob; r.al = al; r.qt = qt;
        r.rep = rep; r.st = st; r.fa = fa;
        vecs.push_back(r);
    endfunction

    // Observed outputs as {porta_aberta, motor_abrir, motor_fechar, liberar, falha, estado}.
    function automatic logic [6:0] obs();
        return {porta_aberta, motor_abrir, motor_fechar, liberar_movimento, falha_porta, estado};
    endfunction

    function automatic logic [6:0] expect_of(input logic [1:0] st, input logic fa);
        return {st == AT, st == AB, st == FC, st == FD, fa, st};
    endfunction

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = obs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (aberta,m_abr,m_fech,liberar,falha,estado)",
                     name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        chegou_andar = 0; botao_abrir = 0; botao_fechar = 0;
        sensor_obstrucao = 0; alerta = 0; quantidade_pessoas = 2'd0;
    endtask

    initial begin
        // first edge after reset release
        v(0,0,0,0,0,0, 1, FD,0);
        v(0,0,1,0,0,0, 2, FD,0);            // close button ignored while closed
        // basic cycle: 4 opening, 16 open, 4 closing
        v(1,0,0,0,0,0, 1, AB,0);
        v(0,0,0,0,0,0, 3, AB,0);
        v(0,0,0,0,0,0,16, AT,0);
        v(0,0,0,0,0,0, 4, FC,0);
        v(0,0,0,0,0,0, 2, FD,0);
        // open button at timer 10 restarts the open window
        v(0,1,0,0,0,0, 1, AB,0);
        v(0,0,0,0,0,0, 3, AB,0);
        v(0,0,0,0,0,0,11, AT,0);
        v(0,1,0,0,0,0, 1, AT,0);
        v(0,0,0,0,0,0,15, AT,0);
        v(0,0,0,0,0,0, 4, FC,0);
        v(0,0,0,0,0,0, 1, FD,0);
        // close button; opening ignores close/obstruction/arrival; full car blocks close
        v(1,0,0,0,0,0, 1, AB,0);
        v(1,0,1,1,0,0, 3, AB,0);
        v(0,0,0,0,0,0, 2, AT,0);
        v(0,0,1,0,0,3, 3, AT,0);
        v(0,1,1,0,0,0, 1, AT,0);            // abrir beats fechar
        v(0,0,1,0,0,1, 1, FC,0);
        v(0,0,0,0,0,0, 3, FC,0);
        v(0,0,0,0,0,0, 1, FD,0);
        // close with alerta held: stays open, closes 16 cycles after alerta drops
        v(1,0,0,0,0,0, 1, AB,0);
        v(0,0,0,0,0,0, 3, AB,0);
        v(0,0,0,0,0,0, 1, AT,0);
        v(0,0,1,0,1,0,30, AT,0);
        v(0,0,0,0,0,0,15, AT,0);
        v(0,0,0,0,0,0, 4, FC,0);
        v(0,0,0,0,0,0, 1, FD,0);
        // three obstruction reopenings -> falha; second one lands on the expiry edge
        v(1,0,0,0,0,0, 1, AB,0);
        v(0,0,0,0,0,0, 3, AB,0);
        v(0,0,0,0,0,0,16, AT,0);
        v(0,0,0,0,0,0, 2, FC,0);
        v(0,0,0,1,0,0, 1, AB,0);
        v(0,0,0,0,0,0, 3, AB,0);
        v(0,0,0,0,0,0,16, AT,0);
        v(0,0,0,0,0,0, 4, FC,0);
        v(0,0,0,1,0,0, 1, AB,0);
        v(0,0,0,0,0,0, 3, AB,0);
        v(0,0,0,0,0,0,16, AT,0);
        v(0,0,0,0,0,0, 2, FC,0);
        v(0,0,0,1,0,0, 1, AB,1);
        v(0,0,0,0,0,0, 3, AB,1);
        v(0,0,0,0,0,0,16, AT,1);
        v(0,0,0,0,0,0, 2, FC,1);
        v(0,0,0,1,0,0, 1, AB,1);            // saturated, still reopens
        v(0,0,0,0,0,0, 3, AB,1);
        v(0,0,0,0,0,0,16, AT,1);
        v(0,0,0,0,0,0, 4, FC,1);
        v(0,0,0,0,0,0, 1, FD,0);            // clean close clears the fault

        idle_inputs();
        reset = 1'b1;
        #1;
        check("reset_async", 7'b0);
        repeat (2) @(posedge clock);
        #1;
        check("reset_held", 7'b0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            for (int j = 0; j < vecs[i].rep; j++) begin
                chegou_andar       = vecs[i].ch;
                botao_abrir        = vecs[i].ab;
                botao_fechar       = vecs[i].fe;
                sensor_obstrucao   = vecs[i].ob;
                alerta             = vecs[i].al;
                quantidade_pessoas = vecs[i].qt;
                @(posedge clock);
                #1;
                check($sformatf("vec%0d_cyc%0d", i, j), expect_of(vecs[i].st, vecs[i].fa));
            end
        end

        // reset in the middle of opening: outputs drop without a clock edge
        idle_inputs();
        chegou_andar = 1;
        @(posedge clock); #1;
        chegou_andar = 0;
        check("pre_reset_opening", expect_of(AB, 0));
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        check("reset_mid_opening", 7'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        check("reset_mid_held", 7'b0);
        @(posedge clock); #1;
        check("first_edge_after_reset", expect_of(FD, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
